// File: rtl/aes_cmd_pkg.sv
// aes_cmd_pkg: shared state encoding, ASCII constants and byte classification helpers for the AES command controller
package aes_cmd_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GOT    = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_SWITCH = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_P   = 8'h50;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_D   = 8'h44;
  localparam logic [7:0] CH_C   = 8'h43;
  localparam logic [7:0] CH_Q   = 8'h3F;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_ACK = 8'h4B;
  localparam logic [7:0] CH_NAK = 8'h4E;
  localparam logic [7:0] CH_TMO = 8'h54;
  function automatic logic [7:0] fold_lc(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction
  function automatic logic is_cmd(input logic [7:0] b);
    logic [7:0] f;
    f = fold_lc(b);
    return f == fold_lc(CH_S) || f == fold_lc(CH_P) || f == fold_lc(CH_E) ||
           f == fold_lc(CH_D) || f == fold_lc(CH_C) || f == CH_Q;
  endfunction
  function automatic logic is_term(input logic [7:0] b);
    return b == CH_CR || b == CH_LF;
  endfunction
endpackage

// File: rtl/aes_cmd_ctrl_timer.sv
// cmd_timer: loadable down-counter; expired is high once the count has run down to zero
module cmd_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/aes_cmd_ctrl.sv
// aes_cmd_ctrl: parses letter+CR/LF UART commands into work/enc controls with a drain-before-reverse sequence and ACK/NAK replies
module aes_cmd_ctrl
  import aes_cmd_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int CMD_TIMEOUT_MS = 10,
  parameter int DRAIN_MAX      = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       plat_busy,
  output logic       work,
  output logic       enc,
  output logic       clr_cnt,
  output logic       report_req,
  output logic [7:0] ovr_cnt
);
  localparam int TO_CYC = CLK_FREQ / 1000 * CMD_TIMEOUT_MS;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam int W = TW > DW ? TW : DW;
  logic [2:0] state, state_d;
  logic [7:0] cmd_reg, cmd_d, tx_data_d;
  logic work_d, enc_d, tmr_load, tmr_exp, tmr_en, drop;
  logic is_s, is_p, is_e, is_d, is_ed, need_drain;
  logic [W-1:0] tmr_val;
  assign is_s = cmd_reg == fold_lc(CH_S);
  assign is_p = cmd_reg == fold_lc(CH_P);
  assign is_e = cmd_reg == fold_lc(CH_E);
  assign is_d = cmd_reg == fold_lc(CH_D);
  assign is_ed = is_e || is_d;
  assign need_drain = is_ed && is_e != enc && work;
  assign tmr_en = state == ST_GOT || state == ST_DRAIN;
  assign drop = rx_valid && (state == ST_EXEC || state == ST_DRAIN || state == ST_SWITCH || state == ST_RESP);
  assign tx_valid = state == ST_RESP;
  assign clr_cnt = state == ST_EXEC && cmd_reg == fold_lc(CH_C);
  assign report_req = state == ST_EXEC && cmd_reg == CH_Q;
  // one timer serves both the GOT timeout and the DRAIN bound; they never overlap
  cmd_timer #(.W(W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .load_val(tmr_val), .en(tmr_en), .expired(tmr_exp)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd_reg <= '0;
      work    <= 1'b0;
      enc     <= 1'b1;
      tx_data <= '0;
      ovr_cnt <= '0;
    end else begin
      state   <= state_d;
      cmd_reg <= cmd_d;
      work    <= work_d;
      enc     <= enc_d;
      tx_data <= tx_data_d;
      ovr_cnt <= ovr_cnt + 8'(drop && ovr_cnt != 8'hFF);
    end
  always_comb begin
    state_d = state;
    cmd_d = cmd_reg;
    tmr_load = 1'b0;
    tmr_val = '0;
    case (state)
      ST_IDLE:
        if (rx_valid && is_cmd(rx_data)) begin
          state_d = ST_GOT;
          cmd_d = fold_lc(rx_data);
          tmr_load = 1'b1;
          tmr_val = W'(TO_CYC - 1);
        end else if (rx_valid && !is_term(rx_data)) state_d = ST_RESP;
      ST_GOT:
        if (rx_valid) state_d = is_term(rx_data) ? ST_EXEC : ST_RESP;
        else if (tmr_exp) state_d = ST_IDLE;
      ST_EXEC:
        if (need_drain) begin
          state_d = ST_DRAIN;
          tmr_load = 1'b1;
          tmr_val = W'(DRAIN_MAX - 1);
        end else state_d = ST_RESP;
      ST_DRAIN:  if (!plat_busy || tmr_exp) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_RESP;
      ST_RESP:   if (tx_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  // enc flips on DRAIN exit and work returns one cycle later in SWITCH, so they never change together
  always_comb begin
    work_d = work;
    enc_d = enc;
    tx_data_d = tx_data;
    case (state)
      ST_IDLE: if (rx_valid && !is_cmd(rx_data) && !is_term(rx_data)) tx_data_d = CH_NAK;
      ST_GOT:  if (rx_valid && !is_term(rx_data)) tx_data_d = CH_NAK;
      ST_EXEC:
        if (need_drain) work_d = 1'b0;
        else begin
          work_d = is_s ? 1'b1 : is_p ? 1'b0 : work;
          enc_d = is_ed ? is_e : enc;
          tx_data_d = CH_ACK;
        end
      ST_DRAIN:
        if (!plat_busy || tmr_exp) begin
          enc_d = is_e;
          tx_data_d = plat_busy ? CH_TMO : CH_ACK;
        end
      ST_SWITCH: work_d = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// tb_aes_cmd_ctrl: directed scenario tests for the AES command controller with a shortened timeout and drain bound
module tb_aes_cmd_ctrl;
  localparam int TO_CYC = 100;
  localparam int DMAX = 300;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, tx_ready = 1'b1, plat_busy = 1'b0;
  logic [7:0] tx_data, ovr_cnt;
  logic tx_valid, work, enc, clr_cnt, report_req;
  int total = 0, bad = 0, rep_pulses = 0, clr_pulses = 0;
  aes_cmd_ctrl #(.CLK_FREQ(100_000), .CMD_TIMEOUT_MS(1), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .plat_busy(plat_busy), .work(work), .enc(enc),
    .clr_cnt(clr_cnt), .report_req(report_req), .ovr_cnt(ovr_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (report_req === 1'b1) rep_pulses++;
    if (clr_cnt === 1'b1) clr_pulses++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (work !== 1'b0) begin bad++; $display("FAIL reset_work got=%b exp=0", work); end
    total++; if (enc !== 1'b1) begin bad++; $display("FAIL reset_enc got=%b exp=1", enc); end
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
    total++; if (clr_cnt !== 1'b0 || report_req !== 1'b0 || ovr_cnt !== 8'h00) begin bad++; $display("FAIL reset_misc got=%b/%b/%h exp=0/0/00", clr_cnt, report_req, ovr_cnt); end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_start();
    send("S");
    send(8'h0D);
    total++; if (work !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL start_early got=%b/%b exp=0/0", work, tx_valid); end
    step();
    total++; if (work !== 1'b1) begin bad++; $display("FAIL start_work got=%b exp=1", work); end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin bad++; $display("FAIL start_ack got=%b/%h exp=1/4b", tx_valid, tx_data); end
    total++; if (enc !== 1'b1) begin bad++; $display("FAIL start_enc got=%b exp=1", enc); end
    step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL start_done got=%b exp=0", tx_valid); end
  endtask
  task automatic test_drain_ok();
    logic ok;
    plat_busy = 1'b1;
    send("d");
    send(8'h0A);
    total++; if (work !== 1'b1) begin bad++; $display("FAIL drain_exec_work got=%b exp=1", work); end
    step();
    total++; if (work !== 1'b0 || enc !== 1'b1) begin bad++; $display("FAIL drain_stop got=%b/%b exp=0/1", work, enc); end
    ok = 1'b1;
    repeat (100) begin
      step();
      if (enc !== 1'b1 || work !== 1'b0 || tx_valid !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL drain_hold got=changed exp=stable"); end
    plat_busy = 1'b0;
    step();
    total++; if (enc !== 1'b0 || work !== 1'b0) begin bad++; $display("FAIL drain_switch got=%b/%b exp=0/0", enc, work); end
    step();
    total++; if (work !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin bad++; $display("FAIL drain_resp got=%b/%b/%h exp=1/1/4b", work, tx_valid, tx_data); end
    step();
  endtask
  task automatic test_drain_forced();
    int n;
    plat_busy = 1'b1;
    send("E");
    send(8'h0D);
    step();
    total++; if (work !== 1'b0 || enc !== 1'b0) begin bad++; $display("FAIL force_stop got=%b/%b exp=0/0", work, enc); end
    n = 0;
    while (enc === 1'b0 && n < 1000) begin
      step();
      n++;
    end
    total++; if (n != DMAX) begin bad++; $display("FAIL force_cycles got=%0d exp=%0d", n, DMAX); end
    total++; if (work !== 1'b0) begin bad++; $display("FAIL force_order got=%b exp=0", work); end
    step();
    total++; if (work !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h54) begin bad++; $display("FAIL force_resp got=%b/%b/%h exp=1/1/54", work, tx_valid, tx_data); end
    plat_busy = 1'b0;
    step();
  endtask
  task automatic test_enc_immediate();
    send("e");
    send(8'h0D);
    step();
    total++; if (tx_data !== 8'h4B || enc !== 1'b1 || work !== 1'b1) begin bad++; $display("FAIL enc_same got=%h/%b/%b exp=4b/1/1", tx_data, enc, work); end
    step();
  endtask
  task automatic test_timeout();
    logic ok;
    send("S");
    ok = 1'b1;
    repeat (TO_CYC + 5) begin
      step();
      if (tx_valid !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok || work !== 1'b1) begin bad++; $display("FAIL timeout_silent got=%b/%b exp=1/1", ok, work); end
    send("P");
    send(8'h0D);
    step();
    total++; if (tx_data !== 8'h4B || tx_valid !== 1'b1 || work !== 1'b0) begin bad++; $display("FAIL timeout_next got=%h/%b/%b exp=4b/1/0", tx_data, tx_valid, work); end
    step();
    send("D");
    send(8'h0D);
    step();
    total++; if (enc !== 1'b0 || work !== 1'b0 || tx_data !== 8'h4B) begin bad++; $display("FAIL idle_enc got=%b/%b/%h exp=0/0/4b", enc, work, tx_data); end
    step();
  endtask
  task automatic test_timeout_edge();
    send("s");
    repeat (TO_CYC - 1) step();
    send(8'h0D);
    step();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B || work !== 1'b1) begin bad++; $display("FAIL timeout_edge got=%b/%h/%b exp=1/4b/1", tx_valid, tx_data, work); end
    step();
  endtask
  task automatic test_nak_report();
    send("X");
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h4E) begin bad++; $display("FAIL nak got=%b/%h exp=1/4e", tx_valid, tx_data); end
    step();
    send(8'h0D);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL nak_cr got=%b exp=0", tx_valid); end
    send("?");
    send(8'h0D);
    total++; if (report_req !== 1'b1 || clr_cnt !== 1'b0) begin bad++; $display("FAIL report_pulse got=%b/%b exp=1/0", report_req, clr_cnt); end
    step();
    total++; if (report_req !== 1'b0 || tx_data !== 8'h4B) begin bad++; $display("FAIL report_ack got=%b/%h exp=0/4b", report_req, tx_data); end
    step();
    send(8'h0A);
    repeat (3) step();
    total++; if (tx_valid !== 1'b0 || rep_pulses != 1 || ovr_cnt !== 8'h00) begin bad++; $display("FAIL report_lf got=%b/%0d/%h exp=0/1/00", tx_valid, rep_pulses, ovr_cnt); end
    send("c");
    send(8'h0D);
    step();
    step();
    total++; if (clr_pulses != 1) begin bad++; $display("FAIL clear_pulses got=%0d exp=1", clr_pulses); end
  endtask
  task automatic test_overrun();
    logic ok;
    tx_ready = 1'b0;
    send("x");
    total++; if (tx_valid !== 1'b1 || ovr_cnt !== 8'h00) begin bad++; $display("FAIL ovr_start got=%b/%h exp=1/00", tx_valid, ovr_cnt); end
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(i[7:0]);
      if (tx_valid !== 1'b1 || tx_data !== 8'h4E) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL ovr_stable got=changed exp=stable"); end
    total++; if (ovr_cnt !== 8'hFF) begin bad++; $display("FAIL ovr_sat got=%h exp=ff", ovr_cnt); end
    tx_ready = 1'b1;
    step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovr_release got=%b exp=0", tx_valid); end
    send("p");
    send(8'h0D);
    step();
    total++; if (tx_data !== 8'h4B || work !== 1'b0) begin bad++; $display("FAIL ovr_after got=%h/%b exp=4b/0", tx_data, work); end
    step();
  endtask
  task automatic test_reset_mid();
    tx_ready = 1'b0;
    send("Q");
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || ovr_cnt !== 8'h00) begin bad++; $display("FAIL mid_reset got=%b/%h/%h exp=0/00/00", tx_valid, tx_data, ovr_cnt); end
    total++; if (enc !== 1'b1 || work !== 1'b0) begin bad++; $display("FAIL mid_reset_ctl got=%b/%b exp=1/0", enc, work); end
    step();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    step();
  endtask
  initial begin
    test_reset();
    test_start();
    test_drain_ok();
    test_drain_forced();
    test_enc_immediate();
    test_timeout();
    test_timeout_edge();
    test_nak_report();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_cmd_ctrl.md
Name: aes_cmd_ctrl

Overview:
- Command controller between the UART byte receiver and the AES verification platform.
- Parses single-letter ASCII commands (letter + CR/LF terminator) and drives the platform's work/enc controls.
- Reversing direction while running follows a safe sequence: stop the stream, drain in-flight blocks, flip enc, restart.
- Returns a one-byte ACK/NAK to the UART transmitter over a valid/ready handshake, and pulses counter-clear and report-request strobes.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- CMD_TIMEOUT_MS, 10, maximum gap between command letter and terminator, in ms.
- DRAIN_MAX, 4096, maximum cycles to wait for plat_busy to fall before forcing the switch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response pending.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- plat_busy  in  1  platform has AES blocks in flight.
- work  out  1  platform run enable.
- enc  out  1  1 = encrypt, 0 = decrypt.
- clr_cnt  out  1  one-cycle pulse: clear total/correct counters.
- report_req  out  1  one-cycle pulse: emit a status report now.
- ovr_cnt  out  8  saturating count of bytes dropped while busy.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: work=0, enc=1, tx_data=8'h00, tx_valid=0, clr_cnt=0, report_req=0, ovr_cnt=0, state=IDLE. Reset mid-operation aborts everything, including a pending tx byte.
- Timeout constant: TO_CYC = CLK_FREQ/1000*CMD_TIMEOUT_MS; timer width = clog2(TO_CYC+1).
- Command letters (case-insensitive):
  - 'S': work=1.
  - 'P': work=0.
  - 'E': enc=1.
  - 'D': enc=0.
  - 'C': pulse clr_cnt.
  - '?': pulse report_req.
- Terminators: 8'h0D or 8'h0A.
- States and transitions:
  - IDLE: a letter byte latches into cmd_reg and goes to GOT; terminator bytes are ignored (CRLF-safe); any other byte loads tx_data='N' and goes to RESP.
  - GOT: timer counts each cycle. Terminator goes to EXEC. Any other byte goes to RESP with 'N'. Timer reaching TO_CYC goes to IDLE silently (command discarded).
  - EXEC (1 cycle):
    - 'S'/'P' update work.
    - 'C'/'?' pulse their strobe exactly once, in this cycle.
    - 'E'/'D' with target enc equal to current enc, or with work=0: update enc immediately.
    - All of the above load 'K' and go to RESP.
    - 'E'/'D' with target enc different from current enc while work=1: work<=0 and go to DRAIN.
  - DRAIN: drain counter increments each cycle. plat_busy=0 goes to SWITCH with resp='K'. Counter reaching DRAIN_MAX goes to SWITCH with resp='T' (forced).
  - SWITCH (1 cycle): enc<=target, work<=1, go to RESP.
  - RESP: tx_valid=1 with tx_data held stable until tx_valid&&tx_ready, then tx_valid=0 and return to IDLE. Handshake completes in the same cycle tx_ready is sampled high.
- Latency: terminator at cycle n gives tx_valid at n+2 for non-drain commands.
- Overrun: an rx_valid byte arriving in EXEC, DRAIN, SWITCH or RESP is dropped and ovr_cnt increments, saturating at 255.
- Simultaneous events: in GOT, rx_valid in the same cycle the timer reaches TO_CYC means the byte wins.
- Switch ordering: work never goes high in the same cycle enc changes during a switch; enc changes only while work=0.

Decomposition:
- Shared package aes_cmd_pkg holds:
  - state encoding localparams;
  - ASCII constants CH_S, CH_P, CH_E, CH_D, CH_C, CH_Q, CH_CR, CH_LF, CH_ACK='K', CH_NAK='N', CH_TMO='T';
  - the lowercase-fold function.
- One natural sub-module: cmd_timer, a loadable down-counter with an expiry flag, reused for the GOT timeout and DRAIN_MAX.

Test Plan:
- Reset, then send 'S',0x0D, tx_ready=1 → work=1 two cycles after the terminator; tx_data=0x4B ('K') for one handshake; enc stays 1.
- work=1, plat_busy=1, send 'd',0x0A → work falls next cycle; enc stays 1 while busy; release plat_busy after 100 cycles → enc=0, then work=1 one cycle later; response 'K'.
- Same as above but plat_busy held high → after DRAIN_MAX cycles enc=0, work=1, response 'T'.
- Send 'S', then no terminator for TO_CYC+5 cycles → no response, work unchanged; a following 'P',0x0D is accepted with 'K'.
- Send 'X',0x0D → 'N' response; then '?',0x0D,0x0A → exactly one report_req pulse, one 'K', and the LF ignored.
- Hold tx_ready=0 in RESP and inject 300 rx bytes → tx_data stable, ovr_cnt=255 (saturated); tx_ready=1 completes the handshake and returns to IDLE.
